bht_pc_ctrl: RTL and testbench

- Parametrised next-generation PC-select and branch-resolution controller for the 3-stage core.
- Adds a direct-mapped table of saturating-counter branch predictors, with lookup in stage 1 and resolution/update in stage 2.
- Adds mispredict recovery, flush generation, stall hold, and branch/mispredict statistics counters.
- Drives the fetch PC mux; the s3 writeback/memory control is unchanged and lives elsewhere.

---
 rtl/bht_pc_ctrl_if.sv | 33 +++
 rtl/bht_pc_ctrl.sv | 133 +++++++++++++
 tb/tb_bht_pc_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bht_pc_ctrl_if.sv
// Bundle between the 3-stage pipeline and the PC-select / branch controller.
// Carries the stage-1 lookup fields, the stage-2 resolution fields and stall/clear controls.
// Returns the PC mux select, the stage-1 kill, the travelling prediction and the statistics counters.
interface bht_pc_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 stall;
    logic [31:0]          pc_s1;
    logic [31:0]          inst_s1;
    logic                 is_jal;
    logic [31:0]          pc_s2;
    logic [31:0]          inst_s2;
    logic                 breq;
    logic                 brlt;
    logic                 cnt_clr;
    logic [2:0]           pc_sel;
    logic                 flush_s1;
    logic                 pred_s2;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    // Pipeline side: drives the instruction stream, consumes the steering decisions.
    modport master (
        output stall, pc_s1, inst_s1, is_jal, pc_s2, inst_s2, breq, brlt, cnt_clr,
        input  pc_sel, flush_s1, pred_s2, branch_cnt, mispred_cnt
    );

    // Controller side.
    modport slave (
        input  stall, pc_s1, inst_s1, is_jal, pc_s2, inst_s2, breq, brlt, cnt_clr,
        output pc_sel, flush_s1, pred_s2, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bht_pc_ctrl.sv
// Next-PC select with a direct-mapped saturating-counter branch predictor, mispredict recovery and stats.
// pc_sel/flush_s1 are combinational on the current stage inputs; prediction and BHT update land one edge later.
// stall freezes every piece of state (valid/pred, BHT, counters) while pc_sel/flush_s1 keep being computed.
// Ports: clk, rst_n (async active-low), bus (bht_pc_ctrl_if.slave: stage-1/stage-2 fields in, steering + stats out).
module bht_pc_ctrl #(
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    bht_pc_ctrl_if.slave  bus
);
    localparam int IDX = $clog2(BHT_DEPTH);

    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
    localparam logic [4:0] OPC_JALR_5   = 5'b11001;

    // Weakly not-taken: largest value whose MSB is still 0.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    typedef enum logic [2:0] {
        SEL_PC4     = 3'd0,
        SEL_ALU     = 3'd1,
        SEL_S1_TGT  = 3'd2,
        SEL_RESET   = 3'd3,
        SEL_RECOVER = 3'd4
    } pc_sel_e;

    logic [CTR_BITS-1:0]  bht [BHT_DEPTH];
    logic                 valid_s2;
    logic                 pred_s2_q;
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_q;

    logic                 br_s1;
    logic [IDX-1:0]       idx_s1;
    logic [IDX-1:0]       idx_s2;
    logic                 p1;
    logic                 br_s2;
    logic                 jalr_s2;
    logic                 cond_s2;
    logic                 mispred_s2;
    pc_sel_e              pc_sel_c;
    logic                 flush_c;

    // Address/opcode bits the controller never looks at.
    logic unused_bits;
    assign unused_bits = ^{bus.pc_s1[31:IDX+2], bus.pc_s1[1:0],
                           bus.pc_s2[31:IDX+2], bus.pc_s2[1:0],
                           bus.inst_s1[31:7], bus.inst_s1[1:0],
                           bus.inst_s2[31:15], bus.inst_s2[11:7], bus.inst_s2[1:0]};

    assign br_s1  = (bus.inst_s1[6:2] == OPC_BRANCH_5);
    assign idx_s1 = bus.pc_s1[IDX+1:2];
    assign idx_s2 = bus.pc_s2[IDX+1:2];
    // Lookup reads the array directly: a same-cycle update to this index is not bypassed.
    assign p1     = bht[idx_s1][CTR_BITS-1];

    assign br_s2   = valid_s2 && (bus.inst_s2[6:2] == OPC_BRANCH_5);
    assign jalr_s2 = valid_s2 && (bus.inst_s2[6:2] == OPC_JALR_5);

    always_comb begin
        cond_s2 = 1'b0;
        unique case (bus.inst_s2[14:12])
            3'b000:         cond_s2 = bus.breq;
            3'b001:         cond_s2 = !bus.breq;
            3'b100, 3'b110: cond_s2 = bus.brlt;
            3'b101, 3'b111: cond_s2 = !bus.brlt;
            default:        cond_s2 = 1'b0;
        endcase
    end

    assign mispred_s2 = br_s2 && (cond_s2 != pred_s2_q);

    // Stage-2 corrections outrank stage-1 steering; only the corrections kill stage 1.
    always_comb begin
        pc_sel_c = SEL_PC4;
        flush_c  = 1'b0;
        if (!rst_n) begin
            pc_sel_c = SEL_RESET;
        end else if (jalr_s2) begin
            pc_sel_c = SEL_ALU;
            flush_c  = 1'b1;
        end else if (mispred_s2 && cond_s2) begin
            pc_sel_c = SEL_ALU;
            flush_c  = 1'b1;
        end else if (mispred_s2) begin
            pc_sel_c = SEL_RECOVER;
            flush_c  = 1'b1;
        end else if (bus.is_jal || (br_s1 && p1)) begin
            pc_sel_c = SEL_S1_TGT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s2      <= 1'b0;
            pred_s2_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (!bus.stall) begin
            valid_s2  <= !flush_c;
            pred_s2_q <= br_s1 && p1 && !flush_c;
            if (bus.cnt_clr) begin
                branch_cnt_q  <= '0;
                mispred_cnt_q <= '0;
            end else begin
                if (br_s2)      branch_cnt_q  <= branch_cnt_q + 1'b1;
                if (mispred_s2) mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
        end else if (!bus.stall && br_s2) begin
            if (cond_s2 && bht[idx_s2] != CTR_MAX)
                bht[idx_s2] <= bht[idx_s2] + CTR_ONE;
            else if (!cond_s2 && bht[idx_s2] != '0)
                bht[idx_s2] <= bht[idx_s2] - CTR_ONE;
        end
    end

    assign bus.pc_sel      = pc_sel_c;
    assign bus.flush_s1    = flush_c;
    assign bus.pred_s2     = pred_s2_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_bht_pc_ctrl.sv
// Directed bench for bht_pc_ctrl with 4-bit statistics counters so wrap-around is reachable.
// Each table row is one cycle: combinational outputs checked mid-cycle, counters checked after the edge.
// Hand-written sequences cover reset, counter wrap and reset arriving during a stall.
module tb_bht_pc_ctrl;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] BF2  = 32'h0000_2063;
    localparam logic [31:0] BLT  = 32'h0000_4063;
    localparam logic [31:0] BGE  = 32'h0000_5063;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] JAL  = 32'h0000_006f;
    localparam logic [31:0] A    = 32'h4000_0000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bht_pc_ctrl_if #(.CNT_WIDTH(4)) bus ();

    bht_pc_ctrl #(.BHT_DEPTH(64), .CTR_BITS(2), .CNT_WIDTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] pc1;
        logic [31:0] i1;
        logic        jal;
        logic [31:0] pc2;
        logic [31:0] i2;
        logic        breq;
        logic        brlt;
        logic        clr;
        logic [2:0]  e_sel;
        logic        e_flush;
        logic        e_pred;
        logic [3:0]  e_br;
        logic [3:0]  e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [31:0] pc1, logic [31:0] i1, logic jal,
                                logic [31:0] pc2, logic [31:0] i2, logic breq, logic brlt,
                                logic clr, logic [2:0] sel, logic fl, logic pr,
                                logic [3:0] br, logic [3:0] mis);
        vec_t v;
        v.stall = st;  v.pc1 = pc1;   v.i1 = i1;     v.jal = jal;
        v.pc2 = pc2;   v.i2 = i2;     v.breq = breq; v.brlt = brlt;
        v.clr = clr;   v.e_sel = sel; v.e_flush = fl; v.e_pred = pr;
        v.e_br = br;   v.e_mis = mis;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall   = v.stall;
        bus.pc_s1   = v.pc1;
        bus.inst_s1 = v.i1;
        bus.is_jal  = v.jal;
        bus.pc_s2   = v.pc2;
        bus.inst_s2 = v.i2;
        bus.breq    = v.breq;
        bus.brlt    = v.brlt;
        bus.cnt_clr = v.clr;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(mk(0, A, BEQ, 0, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0, 0));

        //           stall pc1      i1   jal pc2      i2    breq brlt clr sel fl pr br mis
        tbl.push_back(mk(0, A+32'h00, BEQ, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 0, 0)); // r0
        tbl.push_back(mk(0, A+32'h10, BEQ, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 0, 0)); // r1 weak NT
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BEQ, 1, 0, 0, 1, 1, 0, 1, 1)); // r2 mispred taken
        tbl.push_back(mk(0, A+32'h10, BEQ, 0, A+32'h10, BEQ, 1, 0, 0, 2, 0, 0, 1, 1)); // r3 s2 invalid
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BEQ, 1, 0, 0, 0, 0, 1, 2, 1)); // r4 correct taken
        tbl.push_back(mk(0, A+32'h10, BNE, 0, 32'h0,   NOP,  0, 0, 0, 2, 0, 0, 2, 1)); // r5
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BNE, 1, 0, 0, 4, 1, 1, 3, 2)); // r6 3->2
        tbl.push_back(mk(0, A+32'h10, BNE, 0, 32'h0,   NOP,  0, 0, 0, 2, 0, 0, 3, 2)); // r7
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BNE, 1, 0, 0, 4, 1, 1, 4, 3)); // r8 2->1
        tbl.push_back(mk(0, A+32'h10, BNE, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 4, 3)); // r9
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BNE, 1, 0, 0, 0, 0, 0, 5, 3)); // r10 1->0
        tbl.push_back(mk(0, A+32'h14, NOP, 0, A+32'h10, BNE, 1, 0, 0, 0, 0, 0, 6, 3)); // r11 stays 0
        tbl.push_back(mk(0, A+32'h10, BNE, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 6, 3)); // r12 no underflow
        tbl.push_back(mk(0, A+32'h80, JAL, 1, A+32'h20, JALR, 0, 0, 0, 1, 1, 0, 6, 3)); // r13 JALR wins
        tbl.push_back(mk(0, A+32'h84, NOP, 0, A+32'h20, BEQ, 1, 0, 0, 0, 0, 0, 6, 3)); // r14 invalid s2
        tbl.push_back(mk(0, A+32'h88, NOP, 0, A+32'h80, JAL, 0, 0, 0, 0, 0, 0, 6, 3)); // r15 JAL in s2
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, A+32'h34, NOP, 0, A+32'h30, BEQ, 1, 0, 0, 1, 1, 0, 6, 3)); // r16-18 stalled
        tbl.push_back(mk(0, A+32'h34, NOP, 0, A+32'h30, BEQ, 1, 0, 0, 1, 1, 0, 7, 4)); // r19 released
        tbl.push_back(mk(0, A+32'h30, BEQ, 0, 32'h0,   NOP,  0, 0, 0, 2, 0, 0, 7, 4)); // r20 entry 12 = 2
        tbl.push_back(mk(0, A+32'h34, NOP, 0, A+32'h30, BEQ, 0, 0, 0, 4, 1, 1, 8, 5)); // r21 2->1
        tbl.push_back(mk(0, A+32'h30, BEQ, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 8, 5)); // r22 single update
        tbl.push_back(mk(0, A+32'h34, NOP, 0, A+32'h30, BEQ, 1, 0, 1, 1, 1, 0, 0, 0)); // r23 clr wins
        tbl.push_back(mk(0, A+32'h38, NOP, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 0, 0)); // r24
        tbl.push_back(mk(0, A+32'h44, NOP, 0, A+32'h40, BLT, 0, 1, 0, 1, 1, 0, 1, 1)); // r25 BLT taken
        tbl.push_back(mk(0, A+32'h48, NOP, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 1, 1)); // r26
        tbl.push_back(mk(0, A+32'h54, NOP, 0, A+32'h50, BF2, 1, 1, 0, 0, 0, 0, 2, 1)); // r27 bad func3
        tbl.push_back(mk(0, A+32'h58, NOP, 0, A+32'h50, BGE, 0, 0, 0, 1, 1, 0, 3, 2)); // r28 BGE taken
        tbl.push_back(mk(0, A+32'h5c, NOP, 0, 32'h0,   NOP,  0, 0, 0, 0, 0, 0, 3, 2)); // r29
        tbl.push_back(mk(0, A+32'h60, NOP, 0, 32'h0,   NOP,  0, 0, 1, 0, 0, 0, 0, 0)); // r30 clr

        // Reset: PC select forced to RESET_PC, nothing flushed, state cleared.
        #2;
        chk("rst_pc_sel", 32'(bus.pc_sel), 32'd3);
        chk("rst_flush", 32'(bus.flush_s1), 32'd0);
        chk("rst_pred", 32'(bus.pred_s2), 32'd0);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("rel_flush", 32'(bus.flush_s1), 32'd0);
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(negedge clk);
            chk($sformatf("r%0d_pc_sel", k), 32'(bus.pc_sel), 32'(tbl[k].e_sel));
            chk($sformatf("r%0d_flush", k), 32'(bus.flush_s1), 32'(tbl[k].e_flush));
            chk($sformatf("r%0d_pred", k), 32'(bus.pred_s2), 32'(tbl[k].e_pred));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_branch_cnt", k), 32'(bus.branch_cnt), 32'(tbl[k].e_br));
            chk($sformatf("r%0d_mispred_cnt", k), 32'(bus.mispred_cnt), 32'(tbl[k].e_mis));
        end

        // Correctly predicted not-taken branches every cycle: branch_cnt walks 1..15, 0, 1.
        for (int i = 0; i < 17; i++) begin
            logic [3:0] e_br;
            e_br = 4'(i + 1);
            drive(mk(0, A+32'h64, NOP, 0, A+32'h60, BEQ, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            chk($sformatf("wrap%0d_pc_sel", i), 32'(bus.pc_sel), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_branch_cnt", i), 32'(bus.branch_cnt), 32'(e_br));
            chk($sformatf("wrap%0d_mispred_cnt", i), 32'(bus.mispred_cnt), 32'd0);
        end

        // Reset arriving while a mispredicting branch is held by a stall.
        drive(mk(1, A+32'h64, NOP, 0, A+32'h60, BEQ, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("stallrst_pre_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("stallrst_pre_flush", 32'(bus.flush_s1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("stallrst_pc_sel", 32'(bus.pc_sel), 32'd3);
        chk("stallrst_flush", 32'(bus.flush_s1), 32'd0);
        chk("stallrst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("stallrst_pred", 32'(bus.pred_s2), 32'd0);
        @(negedge clk);
        // Entry 12 was left at 2; reset must bring it back to weakly not-taken.
        drive(mk(0, A+32'h30, BEQ, 0, A+32'h60, BEQ, 1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        #1;
        chk("postrst_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("postrst_flush", 32'(bus.flush_s1), 32'd0);
        @(posedge clk);
        #1;
        chk("postrst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("postrst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
